serial_word_framer: RTL and testbench
=====================================

SERIAL_WORD_FRAMER -- requirements
Module: serial_word_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of data bits per frame.
REQ-002 SHALL have parameter DEPTH, default 2: number of output buffer entries.
REQ-003 SHALL have port Clock, input, 1: the single clock; all state changes on its posedge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port D, input, 1: serial data bit.
REQ-006 SHALL have port D_valid, input, 1: D is sampled only when this is high.
REQ-007 SHALL have port Q, output, WIDTH: head-of-buffer word.
REQ-008 SHALL have port Q_valid, output, 1: Q holds a valid word.
REQ-009 SHALL have port Q_ready, input, 1: consumer accepts Q on a cycle where Q_valid && Q_ready.
REQ-010 SHALL have port Overflow, output, 1: one-cycle pulse when a completed word is dropped.
REQ-011 SHALL have port Frame_err, output, 1: one-cycle pulse on a bad parity or stop bit.
REQ-012 SHALL have port Frame_cnt, output, 8: count of words accepted into the buffer, wrapping 255 -> 0.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, PARITY, STOP and PUSH; PARITY SHALL exist only when WORD_PARITY_EN is defined.
REQ-014 IDLE: D_valid && D==0 (start bit) SHALL go to SHIFT and clear the bit counter; D_valid && D==1 SHALL stay in IDLE.
REQ-015 SHIFT: each D_valid cycle SHALL shift D into sreg[0], with sreg[i] <= sreg[i-1], and increment the bit counter, so the first data bit ends in bit WIDTH-1.
REQ-016 SHIFT: after the WIDTH-th sampled bit the FSM SHALL go to PARITY if WORD_PARITY_EN is defined, else to STOP.
REQ-017 STOP: D_valid && D==1 SHALL go to PUSH; D_valid && D==0 SHALL pulse Frame_err, discard the word and go to IDLE.
REQ-018 PUSH SHALL last exactly one cycle: write sreg to the buffer if it is not full, else pulse Overflow and drop the word; then go to IDLE.
REQ-019 Latency: with the stop bit sampled at edge k, Q_valid SHALL be high after edge k+1 when the buffer was empty.
REQ-020 The buffer SHALL be first-in first-out; Q and Q_valid SHALL be registered and SHALL not depend combinationally on Q_ready.
REQ-021 A push and a pop in the same PUSH cycle with the buffer full SHALL succeed (the pop frees a slot), with no Overflow.
REQ-022 Cycles with D_valid low SHALL hold the FSM state, counter and sreg unchanged in every state except PUSH.
REQ-023 Frame_cnt SHALL increment only on a successful buffer write.
REQ-024 The bit counter SHALL be $clog2(WIDTH+1) bits wide.

Reset
REQ-025 Reset SHALL set: FSM to IDLE, counter 0, sreg 0, buffer empty, Q 0, Q_valid 0, Overflow 0, Frame_err 0, Frame_cnt 0.
REQ-026 Reset asserted mid-frame or mid-PUSH SHALL discard the partial or pending word with no Overflow pulse; Reset SHALL have priority over all other inputs.

Configuration
REQ-027 Macro WORD_PARITY_EN defined: an even-parity bit SHALL follow the data bits and be checked in PARITY; a mismatch SHALL pulse Frame_err and discard the word (return to IDLE); a match SHALL go to STOP.
REQ-028 Macro WORD_PARITY_EN undefined: the frame SHALL be start + WIDTH data bits + stop, with no parity logic present.

Structure
REQ-029 Package serial_framer_pkg SHALL hold the FSM state enum typedef, the default WIDTH (10) and DEPTH (2) constants, and the Frame_cnt width constant.
REQ-030 The buffer SHALL be the sub-module framer_fifo, parameterised by WIDTH and DEPTH, exposing full, empty, push and pop.

Verification
REQ-031 Bits 0, 1,0,1,1,1,0,1,1,1,0, 1 with D_valid held high -> Q=10'b1011101110 with Q_valid high 1 cycle after the stop bit, and Frame_cnt=1.
REQ-032 Same frame with D_valid toggled low every other cycle -> identical Q; no extra words; state held during gaps.
REQ-033 Three frames sent back-to-back with Q_ready=0, DEPTH=2 -> the first two words are buffered, the third triggers an Overflow pulse, Frame_cnt=2, then the two words drain in order when Q_ready=1.
REQ-034 Stop bit sent as 0 -> Frame_err pulses once, no word is pushed, the FSM is in IDLE and the next good frame is received correctly.
REQ-035 Reset asserted after the 5th data bit -> all outputs at reset values, and the following full frame is captured correctly.
REQ-036 With WORD_PARITY_EN defined: data 10'h3FF with parity bit 1 -> Frame_err pulses; with parity bit 0 -> the word is accepted.

Source files
------------

// File: rtl/serial_framer_pkg.sv
// Shared definitions for the serial word framer.
//   - DefaultWidth / DefaultDepth: default data bits per frame and buffer entries.
//   - FrameCntWidth: width of the accepted-word counter.
//   - state_e: receive FSM states; StParity exists only with WORD_PARITY_EN defined.
package serial_framer_pkg;

    localparam int unsigned DefaultWidth  = 10;
    localparam int unsigned DefaultDepth  = 2;
    localparam int unsigned FrameCntWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
`ifdef WORD_PARITY_EN
        StParity,
`endif
        StStop,
        StPush
    } state_e;

endpackage

// File: rtl/framer_fifo.sv
// Small first-in first-out word buffer with a registered head.
// The head entry always lives in mem_q[0], so rdata is a flop output and rvalid is
// registered from the next-state occupancy; neither depends combinationally on pop.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and word
//   pop           read request (ignored when empty)
//   full, empty   occupancy flags
//   rdata, rvalid head word and its valid flag
module framer_fifo
    import serial_framer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic [CntW-1:0]  wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[0];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
        // Entries shift down on a pop, so the write slot moves down with them.
        wr_idx = do_pop ? count_q - CntW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            rvalid  <= 1'b0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
            end
            // Placed after the shift so the incoming word wins its slot.
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && wr_idx == CntW'(i)) begin
                    mem_q[i] <= wdata;
                end
            end
            count_q <= count_d;
            rvalid  <= (count_d != '0);
        end
    end

endmodule

// File: rtl/serial_word_framer.sv
// Serial word framer: receives start(0) + WIDTH data bits (MSB first) [+ even parity]
// + stop(1), and pushes each good word into a DEPTH-entry FIFO.
// Build option: define WORD_PARITY_EN to add an even-parity bit after the data bits.
// Ports:
//   Clock, Reset        clock and synchronous active-high reset
//   D, D_valid          serial bit and its qualifier
//   Q, Q_valid, Q_ready head-of-buffer word with valid/ready handshake
//   Overflow            one-cycle pulse when a completed word is dropped (buffer full)
//   Frame_err           one-cycle pulse on a bad stop (or parity) bit
//   Frame_cnt           count of words accepted into the buffer, wraps at 255
module serial_word_framer
    import serial_framer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     D,
    input  logic                     D_valid,
    output logic [WIDTH-1:0]         Q,
    output logic                     Q_valid,
    input  logic                     Q_ready,
    output logic                     Overflow,
    output logic                     Frame_err,
    output logic [FrameCntWidth-1:0] Frame_cnt
);

    localparam int unsigned CntWidth = $clog2(WIDTH + 1);

    state_e                   state_q;
    logic [CntWidth-1:0]      bit_cnt_q;
    logic [WIDTH-1:0]         sreg_q;
    logic                     overflow_q;
    logic                     frame_err_q;
    logic [FrameCntWidth-1:0] frame_cnt_q;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic push_ok;

    assign fifo_push = (state_q == StPush);
    assign fifo_pop  = Q_ready && !fifo_empty;
    assign push_ok   = !fifo_full || fifo_pop;

    assign Overflow  = overflow_q;
    assign Frame_err = frame_err_q;
    assign Frame_cnt = frame_cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (D_valid && !D) begin
                        state_q   <= StShift;
                        bit_cnt_q <= '0;
                    end
                end
                StShift: begin
                    if (D_valid) begin
                        // First data bit ends up in the MSB after WIDTH shifts.
                        sreg_q    <= {sreg_q[WIDTH-2:0], D};
                        bit_cnt_q <= bit_cnt_q + CntWidth'(1);
                        if (bit_cnt_q == CntWidth'(WIDTH - 1)) begin
`ifdef WORD_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end
                end
`ifdef WORD_PARITY_EN
                StParity: begin
                    if (D_valid) begin
                        // Even parity: data bits plus parity bit hold an even count of ones.
                        if (D != ^sreg_q) begin
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            state_q <= StStop;
                        end
                    end
                end
`endif
                StStop: begin
                    if (D_valid) begin
                        if (D) begin
                            state_q <= StPush;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                StPush: begin
                    if (push_ok) begin
                        frame_cnt_q <= frame_cnt_q + FrameCntWidth'(1);
                    end else begin
                        overflow_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    framer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (Clock),
        .rst    (Reset),
        .push   (fifo_push),
        .wdata  (sreg_q),
        .pop    (fifo_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .rdata  (Q),
        .rvalid (Q_valid)
    );

endmodule

// File: tb/tb_serial_word_framer.sv
// Self-checking bench for serial_word_framer. A queue-based model tracks the buffer
// contents, the accepted-word count and the expected Overflow / Frame_err pulses.
module tb_serial_word_framer;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned DEPTH = 2;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             D;
    logic             D_valid;
    logic [WIDTH-1:0] Q;
    logic             Q_valid;
    logic             Q_ready;
    logic             Overflow;
    logic             Frame_err;
    logic [7:0]       Frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [WIDTH-1:0] mq [$];
    logic [7:0]       m_cnt = '0;
    bit               pend = 1'b0;
    logic [WIDTH-1:0] pend_word = '0;
    bit               rand_ready = 1'b0;
    bit               reset_in_push = 1'b0;
    int               ovf_seen = 0;
    int               err_seen = 0;

    serial_word_framer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .D         (D),
        .D_valid   (D_valid),
        .Q         (Q),
        .Q_valid   (Q_valid),
        .Q_ready   (Q_ready),
        .Overflow  (Overflow),
        .Frame_err (Frame_err),
        .Frame_cnt (Frame_cnt)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1);
    end

    // One clock edge: update the model with the inputs present before the edge,
    // then compare every output 1 time unit after the edge.
    task automatic step(input bit frame_done, input logic [WIDTH-1:0] word, input bit err_exp);
        bit               do_pop;
        bit               has_push;
        bit               exp_ovf;
        bit               exp_err;
        logic [WIDTH-1:0] hw;
        if (rand_ready) Q_ready = 1'($urandom_range(0, 1));
        do_pop   = (mq.size() > 0) && Q_ready;
        has_push = pend;
        hw       = pend_word;
        exp_ovf  = 1'b0;
        exp_err  = 1'b0;
        @(posedge Clock);
        #1;
        if (Reset) begin
            mq.delete();
            pend  = 1'b0;
            m_cnt = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (has_push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(hw);
                    m_cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            pend      = frame_done;
            pend_word = word;
            exp_err   = err_exp;
        end
        if (Overflow === 1'b1) ovf_seen++;
        if (Frame_err === 1'b1) err_seen++;

        n_tests++;
        if (Q_valid !== (mq.size() > 0)) begin
            n_fail++;
            $display("FAIL q_valid @%0t: got %b want %b", $time, Q_valid, mq.size() > 0);
        end
        if (mq.size() > 0) begin
            n_tests++;
            if (Q !== mq[0]) begin
                n_fail++;
                $display("FAIL q_word @%0t: got %b want %b", $time, Q, mq[0]);
            end
        end
        n_tests++;
        if (Frame_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL frame_cnt @%0t: got %0d want %0d", $time, Frame_cnt, m_cnt);
        end
        n_tests++;
        if (Overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL overflow @%0t: got %b want %b", $time, Overflow, exp_ovf);
        end
        n_tests++;
        if (Frame_err !== exp_err) begin
            n_fail++;
            $display("FAIL frame_err @%0t: got %b want %b", $time, Frame_err, exp_err);
        end
    endtask

    // Sends start, data (MSB first), [parity], stop. Gap cycles with D_valid low carry
    // random D. A bad parity bit ends the frame there; a good stop is followed by the
    // PUSH cycle with D_valid low.
    task automatic send_frame(input logic [WIDTH-1:0] word, input bit stop_bit,
                              input bit bad_par, input int gap_pct, input int max_gap);
        logic bits [$];
        int   par_idx;
        bits.push_back(1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(word[i]);
        par_idx = -1;
`ifdef WORD_PARITY_EN
        par_idx = bits.size();
        bits.push_back((^word) ^ bad_par);
`else
        if (bad_par) par_idx = -1;
`endif
        bits.push_back(stop_bit);
        for (int i = 0; i < bits.size(); i++) begin
            for (int g = 0; g < max_gap && $urandom_range(0, 99) < gap_pct; g++) begin
                D_valid = 1'b0;
                D       = 1'($urandom);
                step(1'b0, '0, 1'b0);
            end
            D_valid = 1'b1;
            D       = bits[i];
            if (i == par_idx && bad_par) begin
                step(1'b0, '0, 1'b1);
                D_valid = 1'b0;
                return;
            end
            if (i == bits.size() - 1) begin
                step(stop_bit, word, !stop_bit);
                D_valid = 1'b0;
                if (stop_bit) begin
                    Reset = reset_in_push;
                    step(1'b0, '0, 1'b0);
                    Reset = 1'b0;
                end
            end else begin
                step(1'b0, '0, 1'b0);
            end
        end
    endtask

    task automatic drain();
        Q_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b0);
        Q_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (Q !== '0 || Q_valid !== 1'b0 || Overflow !== 1'b0 || Frame_err !== 1'b0 ||
            Frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: got Q=%b V=%b O=%b E=%b C=%0d want all zero", tag, Q, Q_valid,
                     Overflow, Frame_err, Frame_cnt);
        end
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        D       = 1'b1;
        D_valid = 1'b0;
        Q_ready = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        Reset = 1'b0;
        check_reset_outputs("reset_values");
    endtask

    task automatic test_basic();
        logic [11:0] frame;
        frame = 12'b0_1011101110_1;
`ifdef WORD_PARITY_EN
        send_frame(10'b1011101110, 1'b1, 1'b0, 0, 0);
`else
        for (int i = 11; i >= 0; i--) begin
            D_valid = 1'b1;
            D       = frame[i];
            step(i == 0, 10'b1011101110, 1'b0);
        end
        n_tests++;
        if (Q_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got Q_valid=%b want 0", Q_valid);
        end
        D_valid = 1'b0;
        step(1'b0, '0, 1'b0);
`endif
        n_tests++;
        if (Q_valid !== 1'b1 || Q !== 10'b1011101110 || Frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_frame: got V=%b Q=%b C=%0d want V=1 Q=1011101110 C=1",
                     Q_valid, Q, Frame_cnt);
        end
        drain();
    endtask

    task automatic test_gaps();
        send_frame(10'b1011101110, 1'b1, 1'b0, 100, 1);
        n_tests++;
        if (Q !== 10'b1011101110 || Frame_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL gap_frame: got Q=%b C=%0d want Q=1011101110 C=2", Q, Frame_cnt);
        end
        drain();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic test_overflow();
        logic [7:0] c0;
        c0       = Frame_cnt;
        ovf_seen = 0;
        Q_ready  = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(WIDTH'($urandom), 1'b1, 1'b0, 0, 0);
        n_tests++;
        if (ovf_seen != 1 || (Frame_cnt - c0) !== 8'd2) begin
            n_fail++;
            $display("FAIL overflow_count: got pulses=%0d words=%0d want 1 and 2", ovf_seen,
                     Frame_cnt - c0);
        end
        drain();
    endtask

    task automatic test_stop_err();
        logic [7:0] c0;
        c0       = Frame_cnt;
        err_seen = 0;
        send_frame(WIDTH'($urandom), 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        n_tests++;
        if (err_seen != 1 || Q_valid !== 1'b0 || Frame_cnt !== c0) begin
            n_fail++;
            $display("FAIL stop_err: got pulses=%0d V=%b C=%0d want 1, 0, %0d", err_seen,
                     Q_valid, Frame_cnt, c0);
        end
        send_frame(WIDTH'($urandom), 1'b1, 1'b0, 30, 2);
        drain();
    endtask

    task automatic test_reset_mid();
        D_valid = 1'b1;
        D       = 1'b0;
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            D = 1'($urandom);
            step(1'b0, '0, 1'b0);
        end
        Reset   = 1'b1;
        D_valid = 1'b0;
        step(1'b0, '0, 1'b0);
        Reset = 1'b0;
        check_reset_outputs("reset_midframe");
        send_frame(WIDTH'($urandom), 1'b1, 1'b0, 0, 0);
        drain();
        // Full buffer, then reset during the PUSH of a third word: no Overflow.
        for (int f = 0; f < 2; f++) send_frame(WIDTH'($urandom), 1'b1, 1'b0, 0, 0);
        ovf_seen      = 0;
        reset_in_push = 1'b1;
        send_frame(WIDTH'($urandom), 1'b1, 1'b0, 0, 0);
        reset_in_push = 1'b0;
        step(1'b0, '0, 1'b0);
        n_tests++;
        if (ovf_seen != 0 || Q_valid !== 1'b0 || Frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_push: got pulses=%0d V=%b C=%0d want 0, 0, 0", ovf_seen,
                     Q_valid, Frame_cnt);
        end
    endtask

`ifdef WORD_PARITY_EN
    task automatic test_parity();
        logic [7:0] c0;
        c0       = Frame_cnt;
        err_seen = 0;
        send_frame(10'h3FF, 1'b1, 1'b1, 0, 0);
        n_tests++;
        if (err_seen != 1 || Frame_cnt !== c0) begin
            n_fail++;
            $display("FAIL parity_bad: got pulses=%0d C=%0d want 1, %0d", err_seen, Frame_cnt, c0);
        end
        send_frame(10'h3FF, 1'b1, 1'b0, 0, 0);
        n_tests++;
        if (Q_valid !== 1'b1 || Q !== 10'h3FF) begin
            n_fail++;
            $display("FAIL parity_good: got V=%b Q=%h want 1, 3ff", Q_valid, Q);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            send_frame(WIDTH'($urandom), $urandom_range(0, 7) != 0,
                       $urandom_range(0, 7) == 0, 30, 2);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                D_valid = 1'($urandom);
                D       = 1'b1;
                step(1'b0, '0, 1'b0);
            end
            D_valid = 1'b0;
        end
        rand_ready = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_stop_err();
        test_reset_mid();
`ifdef WORD_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
